cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning per-source result FIFO entries.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy  input  1  global enable; 0 freezes all state.
REQ-005 SHALL have ports srcK_valid  input  1  result offered by unit K (K=0 ALU_MASTER, 1 ALU_SALVER, 2 LOAD_STORE).
REQ-006 SHALL have ports srcK_addr  input  5  destination register of unit K result.
REQ-007 SHALL have ports srcK_data  input  32  result value of unit K.
REQ-008 SHALL have ports srcK_ready  output  1  unit K FIFO can accept this cycle.
REQ-009 SHALL have ports en_wK  output  1  register-status write enable, port K.
REQ-010 SHALL have ports reg_write_addrK  output  5  register-status write address, port K.
REQ-011 SHALL have ports write_dataK  output  32  register-status write data, port K.
REQ-012 SHALL have port cdb_valid  output  1  broadcast to reservation stations valid.
REQ-013 SHALL have port cdb_tag  output  2  producer tag: 1 ALU_MASTER, 2 ALU_SALVER, 3 LOAD_STORE (0 UNLOCKED never driven with cdb_valid=1).
REQ-014 SHALL have ports cdb_addr  output  5  and cdb_data  output  32  broadcast register and value.

Function
REQ-015 SHALL hold one DEPTH-entry FIFO per source with a count 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-016 SHALL drive srcK_ready = (countK < DEPTH), combinational from current count only; a same-cycle pop does not raise ready.
REQ-017 SHALL accept a result on a rising edge when srcK_valid && srcK_ready && rdy.
REQ-018 SHALL discard an accepted result with srcK_addr == 0 (no enqueue, no output, no grant slot).
REQ-019 SHALL grant at most one non-empty FIFO per cycle when rdy=1, round-robin: priority search starts at (last_grant+1) mod 3.
REQ-020 SHALL pop the granted FIFO head on the same edge and register it onto outputs: en_wK=1 for granted K only, reg_write_addrK/write_dataK = head, cdb_valid=1, cdb_tag=K+1, cdb_addr/cdb_data = head.
REQ-021 SHALL, in a cycle with rdy=1 and no grant, register en_w0..2=0, cdb_valid=0, all address/data/tag outputs 0.
REQ-022 SHALL keep non-granted port address/data outputs at 0.
REQ-023 SHALL have latency: accepted at edge E reaches outputs after edge E+1 at earliest; no input-to-output bypass.
REQ-024 SHALL allow push and pop of the same FIFO on one edge; count unchanged, order preserved.
REQ-025 SHALL, when rdy=0, perform no push, pop, pointer, or last_grant update and hold all registered outputs.
REQ-026 SHALL deliver results from any one source in acceptance order; cross-source order is defined solely by REQ-019.
REQ-027 SHALL never overflow: a FIFO with count DEPTH is never written.

Reset
REQ-028 SHALL on rst=0, immediately and asynchronously, clear all FIFO counts and pointers, set last_grant=2 (source 0 highest priority first), and clear en_w0..2, cdb_valid, cdb_tag and all address/data outputs to 0.
REQ-029 SHALL drive srcK_ready=1 for all K while and after reset; results in flight at reset are lost.

Verification
REQ-030 SHALL pass: assert rst=0 mid-stream with FIFOs non-empty -> all outputs 0 same cycle, src0..2_ready=1, no stale result emitted after release.
REQ-031 SHALL pass: src0 pushes addr 5 data 0x00001234 at edge E -> after E+1 en_w0=1, reg_write_addr0=5, write_data0=0x00001234, cdb_valid=1, cdb_tag=1; after E+2 all en_w=0, cdb_valid=0.
REQ-032 SHALL pass: from reset, all three sources push once at same edge -> cdb_tag sequence 1,2,3 on three consecutive cycles, then idle.
REQ-033 SHALL pass: src0 and src1 push every cycle while src2 pushes 3 results back-to-back -> src2_ready drops to 0 when count2=2; src2 granted every third cycle; no src2 result lost or reordered.
REQ-034 SHALL pass: src1 pushes addr 0 data 0xDEADBEEF -> accepted, no en_w1, no cdb_valid ever produced.
REQ-035 SHALL pass: rdy=0 for 4 cycles with src0_valid=1 and FIFOs non-empty -> outputs and counts frozen, src0 not accepted; after rdy=1 draining resumes in the frozen round-robin order.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three per-source result FIFOs drained round-robin,
// one winner per cycle registered onto its register-status port and the CDB.

module cdb_arbiter_chk (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] push,
  input  logic [2:0] full,
  input  logic [2:0] en_w,
  input  logic       cdb_valid,
  input  logic [1:0] cdb_tag
);

  // Structural invariants: no write into a full FIFO, single granted port, legal tag.
  always @(posedge clk) begin
    if (rst) begin
      assert ((push & full) == 3'b000);
      assert ((en_w & (en_w - 3'b001)) == 3'b000);
      assert (cdb_valid == (en_w != 3'b000));
      assert (!cdb_valid || (cdb_tag != 2'd0));
    end
  end

endmodule

module cdb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        src0_valid,
  input  logic [4:0]  src0_addr,
  input  logic [31:0] src0_data,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [4:0]  src1_addr,
  input  logic [31:0] src1_data,
  output logic        src1_ready,
  input  logic        src2_valid,
  input  logic [4:0]  src2_addr,
  input  logic [31:0] src2_data,
  output logic        src2_ready,
  output logic        en_w0,
  output logic        en_w1,
  output logic        en_w2,
  output logic [4:0]  reg_write_addr0,
  output logic [4:0]  reg_write_addr1,
  output logic [4:0]  reg_write_addr2,
  output logic [31:0] write_data0,
  output logic [31:0] write_data1,
  output logic [31:0] write_data2,
  output logic        cdb_valid,
  output logic [1:0]  cdb_tag,
  output logic [4:0]  cdb_addr,
  output logic [31:0] cdb_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? PW'(0) : p + PW'(1);
  endfunction

  logic [2:0]    in_valid;
  logic [4:0]    in_addr [3];
  logic [31:0]   in_data [3];

  logic [4:0]    mem_addr_q [3][DEPTH];
  logic [31:0]   mem_data_q [3][DEPTH];
  logic [CW-1:0] count_q [3];
  logic [CW-1:0] count_d [3];
  logic [PW-1:0] wr_ptr_q [3];
  logic [PW-1:0] wr_ptr_d [3];
  logic [PW-1:0] rd_ptr_q [3];
  logic [PW-1:0] rd_ptr_d [3];
  logic [1:0]    last_grant_q, last_grant_d;

  logic [2:0]    ready, full, nonempty, accept, push, pop;
  logic          grant_vld;
  logic [1:0]    grant_idx;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  logic [2:0]    en_w_q, en_w_d;
  logic [4:0]    waddr_q [3];
  logic [4:0]    waddr_d [3];
  logic [31:0]   wdata_q [3];
  logic [31:0]   wdata_d [3];
  logic          cdb_valid_q, cdb_valid_d;
  logic [1:0]    cdb_tag_q, cdb_tag_d;
  logic [4:0]    cdb_addr_q, cdb_addr_d;
  logic [31:0]   cdb_data_q, cdb_data_d;

  assign in_valid = {src2_valid, src1_valid, src0_valid};
  assign in_addr[0] = src0_addr;
  assign in_addr[1] = src1_addr;
  assign in_addr[2] = src2_addr;
  assign in_data[0] = src0_data;
  assign in_data[1] = src1_data;
  assign in_data[2] = src2_data;

  // FIFO status and handshake; zero-address results are accepted but never enqueued.
  always_comb begin
    ready    = 3'b000;
    full     = 3'b000;
    nonempty = 3'b000;
    accept   = 3'b000;
    push     = 3'b000;
    for (int k = 0; k < 3; k++) begin
      ready[k]    = (count_q[k] < FULL_CNT);
      full[k]     = (count_q[k] == FULL_CNT);
      nonempty[k] = (count_q[k] != CW'(0));
      accept[k]   = in_valid[k] && ready[k] && rdy;
      push[k]     = accept[k] && (in_addr[k] != 5'd0);
    end
  end

  // Round-robin search starting one past the last granted source.
  always_comb begin
    grant_vld = 1'b1;
    grant_idx = 2'd0;
    case (last_grant_q)
      2'd0: begin
        if (nonempty[1])      grant_idx = 2'd1;
        else if (nonempty[2]) grant_idx = 2'd2;
        else if (nonempty[0]) grant_idx = 2'd0;
        else                  grant_vld = 1'b0;
      end
      2'd1: begin
        if (nonempty[2])      grant_idx = 2'd2;
        else if (nonempty[0]) grant_idx = 2'd0;
        else if (nonempty[1]) grant_idx = 2'd1;
        else                  grant_vld = 1'b0;
      end
      default: begin
        if (nonempty[0])      grant_idx = 2'd0;
        else if (nonempty[1]) grant_idx = 2'd1;
        else if (nonempty[2]) grant_idx = 2'd2;
        else                  grant_vld = 1'b0;
      end
    endcase
  end

  assign pop       = (rdy && grant_vld) ? (3'b001 << grant_idx) : 3'b000;
  assign head_addr = mem_addr_q[grant_idx][rd_ptr_q[grant_idx]];
  assign head_data = mem_data_q[grant_idx][rd_ptr_q[grant_idx]];

  // Next-state for counts and pointers; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_grant_d = last_grant_q;
    for (int k = 0; k < 3; k++) begin
      if (push[k]) wr_ptr_d[k] = ptr_inc(wr_ptr_q[k]);
      else         wr_ptr_d[k] = wr_ptr_q[k];
      if (pop[k])  rd_ptr_d[k] = ptr_inc(rd_ptr_q[k]);
      else         rd_ptr_d[k] = rd_ptr_q[k];
      case ({push[k], pop[k]})
        2'b10:   count_d[k] = count_q[k] + CW'(1);
        2'b01:   count_d[k] = count_q[k] - CW'(1);
        default: count_d[k] = count_q[k];
      endcase
    end
    if (rdy && grant_vld) last_grant_d = grant_idx;
    else                  last_grant_d = last_grant_q;
  end

  // Next-state for the broadcast registers; rdy low holds everything.
  always_comb begin
    en_w_d      = en_w_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_addr_d  = cdb_addr_q;
    cdb_data_d  = cdb_data_q;
    if (rdy) begin
      en_w_d      = 3'b000;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = 2'd0;
      cdb_addr_d  = 5'd0;
      cdb_data_d  = 32'd0;
      for (int k = 0; k < 3; k++) begin
        waddr_d[k] = 5'd0;
        wdata_d[k] = 32'd0;
      end
      if (grant_vld) begin
        en_w_d[grant_idx]  = 1'b1;
        waddr_d[grant_idx] = head_addr;
        wdata_d[grant_idx] = head_data;
        cdb_valid_d        = 1'b1;
        cdb_tag_d          = grant_idx + 2'd1;
        cdb_addr_d         = head_addr;
        cdb_data_d         = head_data;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end else begin
      cdb_valid_d = cdb_valid_q;
    end
  end

  // Storage array: written only on push, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (push[k]) begin
        mem_addr_q[k][wr_ptr_q[k]] <= in_addr[k];
        mem_data_q[k][wr_ptr_q[k]] <= in_data[k];
      end
    end
  end

  // FIFO control state; reset leaves source 0 as the first candidate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        count_q[k]  <= CW'(0);
        wr_ptr_q[k] <= PW'(0);
        rd_ptr_q[k] <= PW'(0);
      end
      last_grant_q <= 2'd2;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Registered broadcast outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_w_q      <= 3'b000;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= 2'd0;
      cdb_addr_q  <= 5'd0;
      cdb_data_q  <= 32'd0;
      for (int k = 0; k < 3; k++) begin
        waddr_q[k] <= 5'd0;
        wdata_q[k] <= 32'd0;
      end
    end else begin
      en_w_q      <= en_w_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_addr_q  <= cdb_addr_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign src0_ready      = ready[0];
  assign src1_ready      = ready[1];
  assign src2_ready      = ready[2];
  assign en_w0           = en_w_q[0];
  assign en_w1           = en_w_q[1];
  assign en_w2           = en_w_q[2];
  assign reg_write_addr0 = waddr_q[0];
  assign reg_write_addr1 = waddr_q[1];
  assign reg_write_addr2 = waddr_q[2];
  assign write_data0     = wdata_q[0];
  assign write_data1     = wdata_q[1];
  assign write_data2     = wdata_q[2];
  assign cdb_valid       = cdb_valid_q;
  assign cdb_tag         = cdb_tag_q;
  assign cdb_addr        = cdb_addr_q;
  assign cdb_data        = cdb_data_q;

  cdb_arbiter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .full      (full),
    .en_w      (en_w_q),
    .cdb_valid (cdb_valid_q),
    .cdb_tag   (cdb_tag_q)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin, zero-address
// discard, rdy freeze and back-pressure, all with hand-computed expectations.

module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        src0_valid, src1_valid, src2_valid;
  logic [4:0]  src0_addr, src1_addr, src2_addr;
  logic [31:0] src0_data, src1_data, src2_data;
  logic        src0_ready, src1_ready, src2_ready;
  logic        en_w0, en_w1, en_w2;
  logic [4:0]  reg_write_addr0, reg_write_addr1, reg_write_addr2;
  logic [31:0] write_data0, write_data1, write_data2;
  logic        cdb_valid;
  logic [1:0]  cdb_tag;
  logic [4:0]  cdb_addr;
  logic [31:0] cdb_data;

  logic [4:0]  wa [3];
  logic [31:0] wd [3];

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] bases [3] = '{32'hA000_0000, 32'hB000_0000, 32'hC000_0000};
  int exp_tag [10] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3};
  int exp_idx [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2};
  int exp_r2  [10] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 1};

  cdb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_addr(src1_addr), .src1_data(src1_data), .src1_ready(src1_ready),
    .src2_valid(src2_valid), .src2_addr(src2_addr), .src2_data(src2_data), .src2_ready(src2_ready),
    .en_w0(en_w0), .en_w1(en_w1), .en_w2(en_w2),
    .reg_write_addr0(reg_write_addr0), .reg_write_addr1(reg_write_addr1), .reg_write_addr2(reg_write_addr2),
    .write_data0(write_data0), .write_data1(write_data1), .write_data2(write_data2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_addr(cdb_addr), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  assign wa[0] = reg_write_addr0;
  assign wa[1] = reg_write_addr1;
  assign wa[2] = reg_write_addr2;
  assign wd[0] = write_data0;
  assign wd[1] = write_data1;
  assign wd[2] = write_data2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src0_valid = 1'b0; src0_addr = 5'd0; src0_data = 32'd0;
    src1_valid = 1'b0; src1_addr = 5'd0; src1_data = 32'd0;
    src2_valid = 1'b0; src2_addr = 5'd0; src2_data = 32'd0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en_w"}, 32'({en_w2, en_w1, en_w0}), 32'd0);
    check({tag, "_cdb_valid"}, 32'(cdb_valid), 32'd0);
    check({tag, "_cdb_tag"}, 32'(cdb_tag), 32'd0);
    check({tag, "_cdb_addr"}, 32'(cdb_addr), 32'd0);
    check({tag, "_cdb_data"}, cdb_data, 32'd0);
    for (int j = 0; j < 3; j++) begin
      check({tag, "_port_addr"}, 32'(wa[j]), 32'd0);
      check({tag, "_port_data"}, wd[j], 32'd0);
    end
  endtask

  task automatic check_grant(input string tag, input int k, input logic [4:0] a, input logic [31:0] d);
    logic [2:0] oh;
    oh = 3'b001 << k;
    check({tag, "_en_w"}, 32'({en_w2, en_w1, en_w0}), 32'(oh));
    check({tag, "_cdb_valid"}, 32'(cdb_valid), 32'd1);
    check({tag, "_cdb_tag"}, 32'(cdb_tag), 32'(k + 1));
    check({tag, "_cdb_addr"}, 32'(cdb_addr), 32'(a));
    check({tag, "_cdb_data"}, cdb_data, d);
    for (int j = 0; j < 3; j++) begin
      check({tag, "_port_addr"}, 32'(wa[j]), (j == k) ? 32'(a) : 32'd0);
      check({tag, "_port_data"}, wd[j], (j == k) ? d : 32'd0);
    end
  endtask

  task automatic check_readies(input string tag);
    check({tag, "_ready"}, 32'({src2_ready, src1_ready, src0_ready}), 32'h7);
  endtask

  initial begin
    logic [2:0] acc;
    int idx [3];

    // Power-on reset
    rst = 1'b1; rdy = 1'b1;
    idle_inputs();
    #1 rst = 1'b0;
    #2;
    check_idle("reset");
    check_readies("reset");
    tick(); tick();
    rst = 1'b1;

    // Single result: two-edge latency, then idle
    src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 32'h0000_1234;
    tick();
    idle_inputs();
    check_idle("lat_e");
    tick();
    check_grant("lat_e1", 0, 5'd5, 32'h0000_1234);
    tick();
    check_idle("lat_e2");

    // Asynchronous reset mid-stream drops everything queued
    src0_valid = 1'b1; src0_addr = 5'd7; src0_data = 32'd11;
    src1_valid = 1'b1; src1_addr = 5'd8; src1_data = 32'd22;
    src2_valid = 1'b1; src2_addr = 5'd9; src2_data = 32'd33;
    tick();
    idle_inputs();
    tick();
    check_grant("mid_pre", 1, 5'd8, 32'd22);
    #2 rst = 1'b0;
    #1;
    check_idle("mid_async");
    check_readies("mid_async");
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("mid_nostale");
    end

    // From reset, three simultaneous results drain as tags 1,2,3
    src0_valid = 1'b1; src0_addr = 5'd10; src0_data = 32'hAAAA_0000;
    src1_valid = 1'b1; src1_addr = 5'd11; src1_data = 32'hBBBB_0001;
    src2_valid = 1'b1; src2_addr = 5'd12; src2_data = 32'hCCCC_0002;
    tick();
    idle_inputs();
    check_idle("rr_e0");
    tick();
    check_grant("rr_1", 0, 5'd10, 32'hAAAA_0000);
    tick();
    check_grant("rr_2", 1, 5'd11, 32'hBBBB_0001);
    tick();
    check_grant("rr_3", 2, 5'd12, 32'hCCCC_0002);
    tick();
    check_idle("rr_done");

    // Zero destination register is swallowed
    src1_valid = 1'b1; src1_addr = 5'd0; src1_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      check("zero_src1_ready", 32'(src1_ready), 32'd1);
      tick();
      check_idle("zero_out");
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle("zero_after");
    end

    // rdy freeze with queued results and a pending src0 offer
    src0_valid = 1'b1; src0_addr = 5'd13; src0_data = 32'h0000_0001;
    src1_valid = 1'b1; src1_addr = 5'd14; src1_data = 32'h0000_0002;
    src2_valid = 1'b1; src2_addr = 5'd15; src2_data = 32'h0000_0003;
    tick();
    idle_inputs();
    tick();
    check_grant("frz_pre", 0, 5'd13, 32'h0000_0001);
    rdy = 1'b0;
    src0_valid = 1'b1; src0_addr = 5'd16; src0_data = 32'h0000_0099;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_grant("frz_hold", 0, 5'd13, 32'h0000_0001);
      check_readies("frz_hold");
    end
    idle_inputs();
    rdy = 1'b1;
    tick();
    check_grant("frz_r1", 1, 5'd14, 32'h0000_0002);
    tick();
    check_grant("frz_r2", 2, 5'd15, 32'h0000_0003);
    tick();
    check_idle("frz_end");

    // Back-pressure: src0/src1 always offering, src2 offers three results
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idx[0] = 0; idx[1] = 0; idx[2] = 0;
    for (int k = 0; k < 10; k++) begin
      src0_valid = 1'b1; src0_addr = 5'd1; src0_data = bases[0] + 32'(idx[0]);
      src1_valid = 1'b1; src1_addr = 5'd2; src1_data = bases[1] + 32'(idx[1]);
      src2_valid = (idx[2] < 3); src2_addr = 5'd3; src2_data = bases[2] + 32'(idx[2]);
      check("bp_src2_ready", 32'(src2_ready), 32'(exp_r2[k]));
      acc = {src2_valid && src2_ready, src1_valid && src1_ready, src0_valid && src0_ready};
      tick();
      for (int s = 0; s < 3; s++) begin
        if (acc[s]) idx[s]++;
      end
      if (exp_tag[k] == 0) begin
        check_idle("bp_idle");
      end else begin
        check_grant("bp_grant", exp_tag[k] - 1, 5'(exp_tag[k]),
                    bases[exp_tag[k] - 1] + 32'(exp_idx[k]));
      end
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
